// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants for the register-file dump reader: FSM encoding, record
// length and the index-byte header format.
package regfile_dump_reader_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int         BYTES_PER_REC = 5;
    localparam logic [2:0] LAST_K        = 3'(BYTES_PER_REC - 1);

    // Record header: register index zero-extended into one byte.
    function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
        return {3'b000, idx};
    endfunction

endpackage

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-high clear.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ctrl_writeEnable,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] Out
);

    always_ff @(posedge clock or posedge clr) begin
        if (clr)
            Out <= '0;
        else if (ctrl_writeEnable)
            Out <= In;
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG through one read port and emits
// each as a 5-byte record (index, then value MSB first) on a valid/ready stream.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clock,
    input  logic        clr,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  ctrl_readReg,
    input  logic [31:0] data_readReg,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    logic [2:0]  state;
    logic [4:0]  idx;
    logic [2:0]  k;
    logic [31:0] snap;

    // Snapshot is loaded once per record so later register-file writes
    // cannot alter bytes already being streamed.
    register #(.WIDTH(32)) u_snap (
        .clock            (clock),
        .clr              (clr),
        .ctrl_writeEnable (state == ST_CAPTURE),
        .In               (data_readReg),
        .Out              (snap)
    );

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            idx   <= FIRST_IDX;
            k     <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            idx   <= FIRST_IDX;
            k     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= FIRST_IDX;
                    k   <= '0;
                    if (start)
                        state <= ST_ADDR;
                end
                ST_ADDR:
                    state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    k     <= '0;
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (k == LAST_K) begin
                            k <= '0;
                            if (idx == LAST_IDX) begin
                                state <= ST_DONE;
                            end else begin
                                idx   <= idx + 5'd1;
                                state <= ST_ADDR;
                            end
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                ST_DONE:
                    state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_byte = 8'h00;
        if (state == ST_SEND) begin
            case (k)
                3'd0:    out_byte = hdr_byte(idx);
                3'd1:    out_byte = snap[31:24];
                3'd2:    out_byte = snap[23:16];
                3'd3:    out_byte = snap[15:8];
                3'd4:    out_byte = snap[7:0];
                default: out_byte = 8'h00;
            endcase
        end
    end

    assign ctrl_readReg = (state == ST_ADDR || state == ST_CAPTURE) ? idx : 5'd0;
    assign out_valid    = (state == ST_SEND);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench: full dump, backpressure, snapshot, abort,
// clear and a narrowed register range on a second instance.
module tb_regfile_dump_reader;

    logic        clock, clr;
    logic        a_start, a_abort, a_ready, a_valid, a_busy, a_done;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic [7:0]  a_byte;
    logic        b_start, b_abort, b_ready, b_valid, b_busy, b_done;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic [7:0]  b_byte;

    logic [31:0] rf [32];
    int n_chk = 0;
    int n_pass = 0;

    assign a_data = rf[a_rd];
    assign b_data = rf[b_rd];

    regfile_dump_reader u_a (
        .clock(clock), .clr(clr), .start(a_start), .abort(a_abort),
        .ctrl_readReg(a_rd), .data_readReg(a_data), .out_byte(a_byte),
        .out_valid(a_valid), .out_ready(a_ready), .busy(a_busy), .done(a_done)
    );

    regfile_dump_reader #(.FIRST_REG(29), .LAST_REG(31)) u_b (
        .clock(clock), .clr(clr), .start(b_start), .abort(b_abort),
        .ctrl_readReg(b_rd), .data_readReg(b_data), .out_byte(b_byte),
        .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy), .done(b_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] obyte(input bit s);
        return s ? b_byte : a_byte;
    endfunction
    function automatic logic ovalid(input bit s);
        return s ? b_valid : a_valid;
    endfunction
    function automatic logic odone(input bit s);
        return s ? b_done : a_done;
    endfunction
    function automatic logic obusy(input bit s);
        return s ? b_busy : a_busy;
    endfunction

    task automatic drv_start(input bit s, input logic v);
        if (s) b_start = v; else a_start = v;
    endtask
    task automatic drv_ready(input bit s, input logic v);
        if (s) b_ready = v; else a_ready = v;
    endtask

    // Runs one dump acting as the sink. Expected bytes come from a copy of the
    // register model taken before start; an optional write lands on wr_reg
    // just after its header is accepted, i.e. during its SEND.
    task automatic dump(input bit s, input int first, input int last,
                        input int stall_reg, input int stall_k, input int stall_n,
                        input int wr_reg, input logic [31:0] wr_val,
                        input int restart_pos, input int exp_done, input string tag);
        logic [31:0] pre [32];
        logic [7:0]  expb;
        int pos, total, cyc, done_cyc, left, r, kk;
        for (int i = 0; i < 32; i++) pre[i] = rf[i];
        total = (last - first + 1) * 5;
        pos = 0; done_cyc = -1; left = stall_n;
        drv_ready(s, 1'b1);
        drv_start(s, 1'b1);
        tick();
        drv_start(s, 1'b0);
        cyc = 1;
        while (cyc < 400) begin
            if (odone(s)) begin
                done_cyc = cyc;
                break;
            end
            drv_start(s, pos == restart_pos);
            if (ovalid(s)) begin
                r  = first + pos / 5;
                kk = pos % 5;
                expb = (kk == 0) ? 8'(r) : 8'(pre[r] >> (8 * (4 - kk)));
                if (r == stall_reg && kk == stall_k && left > 0) begin
                    drv_ready(s, 1'b0);
                    left--;
                    chk({tag, "_stall_byte"}, 32'(obyte(s)), 32'(expb));
                end else begin
                    drv_ready(s, 1'b1);
                    chk({tag, "_byte"}, 32'(obyte(s)), 32'(expb));
                    pos++;
                    if (r == wr_reg && kk == 0) rf[wr_reg] = wr_val;
                end
            end else begin
                drv_ready(s, 1'b1);
            end
            tick();
            cyc++;
        end
        drv_start(s, 1'b0);
        drv_ready(s, 1'b1);
        chk({tag, "_nbytes"}, 32'(pos), 32'(total));
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        tick();
        chk({tag, "_done_one_cycle"}, 32'(odone(s)), 32'd0);
        chk({tag, "_idle_after"}, 32'(obusy(s)), 32'd0);
    endtask

    initial begin
        int  found;
        int  bad;
        clr = 1'b1;
        a_start = 0; a_abort = 0; a_ready = 1;
        b_start = 0; b_abort = 0; b_ready = 1;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | 32'(i);
        tick(); tick();
        chk("rst_byte",  32'(a_byte),  32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_rd",    32'(a_rd),    32'h0);
        chk("rst_busy",  32'(a_busy),  32'h0);
        chk("rst_done",  32'(a_done),  32'h0);
        chk("rst_b_busy", 32'(b_busy), 32'h0);
        clr = 1'b0;
        tick();

        // Full 32-register dump, sink always ready
        dump(0, 0, 31, -1, 0, 0, -1, 32'h0, -1, 225, "full");

        // Three stall cycles on k=2 of register 7
        dump(0, 0, 31, 7, 2, 3, -1, 32'h0, -1, 228, "stall");

        // Snapshot: register 4 rewritten during its own SEND
        rf[4] = 32'h1111_1111;
        dump(0, 0, 31, -1, 0, 0, 4, 32'h2222_2222, -1, 225, "snap_old");
        chk("snap_rf_written", rf[4], 32'h2222_2222);
        dump(0, 0, 31, -1, 0, 0, -1, 32'h0, -1, 225, "snap_new");

        // abort beats start in IDLE
        a_start = 1; a_abort = 1;
        tick();
        a_start = 0; a_abort = 0;
        chk("abort_vs_start_busy", 32'(a_busy), 32'h0);

        // Abort during SEND of register 10
        a_start = 1;
        tick();
        a_start = 0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (a_valid && a_byte == 8'h0A) found = 1;
            else tick();
        end
        chk("abort_reach_reg10", 32'(found), 32'd1);
        a_abort = 1;
        tick();
        a_abort = 0;
        chk("abort_valid", 32'(a_valid), 32'h0);
        chk("abort_busy",  32'(a_busy),  32'h0);
        chk("abort_done",  32'(a_done),  32'h0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_done || a_busy) bad++;
            tick();
        end
        chk("abort_no_done", 32'(bad), 32'd0);

        // Restart after abort begins at FIRST_REG
        a_start = 1;
        tick();
        a_start = 0;
        tick();
        chk("restart_busy", 32'(a_busy), 32'h1);
        tick();
        chk("restart_valid", 32'(a_valid), 32'h1);
        chk("restart_hdr",   32'(a_byte),  32'h00);
        tick();
        chk("restart_b1",    32'(a_byte),  32'hA5);

        // Asynchronous clear mid-SEND
        a_ready = 0;
        #1;
        clr = 1'b1;
        #1;
        chk("clr_valid", 32'(a_valid), 32'h0);
        chk("clr_byte",  32'(a_byte),  32'h0);
        chk("clr_busy",  32'(a_busy),  32'h0);
        chk("clr_done",  32'(a_done),  32'h0);
        tick();
        clr = 1'b0;
        a_ready = 1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (a_valid || a_busy || a_done) bad++;
        end
        chk("clr_stay_idle", 32'(bad), 32'd0);

        // Narrow range 29..31 with a second start while busy
        dump(1, 29, 31, -1, 0, 0, -1, 32'h0, 7, 22, "range");
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (b_busy || b_valid) bad++;
        end
        chk("range_restart_ignored", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
